pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the RV32I in-order pipeline. It watches the instruction held in decode, the instructions in execute and memory, branch/jump resolution and data-memory busy. From these it generates the stall and flush controls for the fetch, decode and execute stage registers. It sits beside the decode stage and drives its STALL/FLUSH inputs, so decode itself stays free of scheduling logic.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/hazard_detect.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared RV32I opcode constants and pipeline_ctrl FSM state encoding.
// Also used by decode and execute.
package pipeline_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {
        StRun      = 1'b0,
        StRedirect = 1'b1
    } ctrl_state_e;

    // Every opcode reads rs1 except the three that only use an immediate or PC.
    function automatic logic uses_rs1(input logic [6:0] op);
        logic used;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL:                           used = 1'b0;
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG: used = 1'b1;
            default:                                            used = 1'b1;
        endcase
        return used;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational read-after-write hazard check for the instruction in decode.
// PIPELINE_CTRL_FORWARD_EN selects load-use-only checking (full forwarding).
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       d_valid_i,
    input  logic [6:0] d_opcode_i,
    input  logic [4:0] d_reg_s1_i,
    input  logic [4:0] d_reg_s2_i,
    input  logic       e_valid_i,
    input  logic [6:0] e_opcode_i,
    input  logic [4:0] e_reg_d_i,
    input  logic       m_valid_i,
    input  logic [4:0] m_reg_d_i,
    output logic       hazard_o
);

    logic use_s1;
    logic use_s2;
    logic e_match;

    assign use_s1 = uses_rs1(d_opcode_i);
    assign use_s2 = uses_rs2(d_opcode_i);

    assign e_match = (e_reg_d_i != 5'd0) &&
                     ((use_s1 && (d_reg_s1_i == e_reg_d_i)) ||
                      (use_s2 && (d_reg_s2_i == e_reg_d_i)));

`ifdef PIPELINE_CTRL_FORWARD_EN
    logic unused_m;
    assign unused_m = ^{m_valid_i, m_reg_d_i};

    assign hazard_o = d_valid_i && e_valid_i && (e_opcode_i == OP_LOAD) && e_match;
`else
    logic m_match;
    logic unused_e_op;
    assign unused_e_op = ^e_opcode_i;

    assign m_match = (m_reg_d_i != 5'd0) &&
                     ((use_s1 && (d_reg_s1_i == m_reg_d_i)) ||
                      (use_s2 && (d_reg_s2_i == m_reg_d_i)));

    assign hazard_o = d_valid_i && ((e_valid_i && e_match) || (m_valid_i && m_match));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the RV32I in-order pipeline, with a saturating stall counter.
// Build option PIPELINE_CTRL_FORWARD_EN (applied in hazard_detect) enables forwarding.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_valid_i,
    input  logic [6:0]       d_opcode_i,
    input  logic [4:0]       d_reg_s1_i,
    input  logic [4:0]       d_reg_s2_i,
    input  logic             e_valid_i,
    input  logic [6:0]       e_opcode_i,
    input  logic [4:0]       e_reg_d_i,
    input  logic             m_valid_i,
    input  logic [4:0]       m_reg_d_i,
    input  logic             e_jmp_do_i,
    input  logic             m_busy_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    hazard_detect u_hazard_detect (
        .d_valid_i  (d_valid_i),
        .d_opcode_i (d_opcode_i),
        .d_reg_s1_i (d_reg_s1_i),
        .d_reg_s2_i (d_reg_s2_i),
        .e_valid_i  (e_valid_i),
        .e_opcode_i (e_opcode_i),
        .e_reg_d_i  (e_reg_d_i),
        .m_valid_i  (m_valid_i),
        .m_reg_d_i  (m_reg_d_i),
        .hazard_o   (hazard)
    );

    always_comb begin
        state_d   = state_q;
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StRun: begin
                    // A jump under M_BUSY stays held in execute and re-presents later.
                    if (m_busy_i) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                    end else if (e_jmp_do_i) begin
                        flush_d_o = 1'b1;
                        flush_e_o = 1'b1;
                        state_d   = StRedirect;
                    end else if (hazard) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        flush_e_o = 1'b1;
                    end
                end
                StRedirect: begin
                    flush_d_o = 1'b1;
                    if (m_busy_i) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_f_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl; expectations adapt to PIPELINE_CTRL_FORWARD_EN.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

`ifdef PIPELINE_CTRL_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    // {stall_f, stall_d, stall_e, flush_d, flush_e}
    localparam logic [4:0] CtlNone   = 5'b00000;
    localparam logic [4:0] CtlHazard = 5'b11001;
    localparam logic [4:0] CtlBusy   = 5'b11100;
    localparam logic [4:0] CtlJump   = 5'b00011;
    localparam logic [4:0] CtlRedir  = 5'b00010;
    localparam logic [4:0] CtlRdBusy = 5'b11110;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid, e_valid, m_valid, e_jmp, m_busy;
    logic [6:0] d_op, e_op;
    logic [4:0] d_rs1, d_rs2, e_rd, m_rd;
    logic       sf, sd, se, fd, fe;
    logic [3:0] cnt;
    logic [4:0] ctl;
    logic [4:0] exp_ctl;
    int         exp_cnt = 0;
    int         vecs = 0;
    int         errs = 0;

    assign ctl = {sf, sd, se, fd, fe};

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .d_valid_i   (d_valid),
        .d_opcode_i  (d_op),
        .d_reg_s1_i  (d_rs1),
        .d_reg_s2_i  (d_rs2),
        .e_valid_i   (e_valid),
        .e_opcode_i  (e_op),
        .e_reg_d_i   (e_rd),
        .m_valid_i   (m_valid),
        .m_reg_d_i   (m_rd),
        .e_jmp_do_i  (e_jmp),
        .m_busy_i    (m_busy),
        .stall_f_o   (sf),
        .stall_d_o   (sd),
        .stall_e_o   (se),
        .flush_d_o   (fd),
        .flush_e_o   (fe),
        .stall_cnt_o (cnt)
    );

    task automatic idle();
        d_valid = 1'b0; d_op = 7'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
        e_valid = 1'b0; e_op = 7'd0; e_rd = 5'd0;
        m_valid = 1'b0; m_rd = 5'd0;
        e_jmp = 1'b0; m_busy = 1'b0;
    endtask

    // Advance one clock; st says whether a stall was expected in the cycle just ended.
    task automatic tick(input bit st);
        @(posedge clk);
        if (rst) exp_cnt = 0;
        else if (st && exp_cnt < 15) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick(1'b0);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        d_valid = 1'b1; d_op = OP_REG; d_rs1 = 5'd3;
        e_valid = 1'b1; e_op = OP_LOAD; e_rd = 5'd3;
        e_jmp = 1'b1; m_busy = 1'b1;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL reset_ctl ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        vecs++;
        if (cnt !== 4'd0) begin
            errs++; $display("FAIL reset_cnt cnt=%0d exp=0", cnt);
        end
        rst = 1'b0;
        idle();
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL reset_release ctl=%b exp=%b", ctl, CtlNone);
        end
    endtask

    task automatic test_load_use();
        idle();
        e_valid = 1'b1; e_op = OP_LOAD; e_rd = 5'd5;
        d_valid = 1'b1; d_op = OP_REG; d_rs1 = 5'd5; d_rs2 = 5'd1;
        #1;
        vecs++;
        if (ctl !== CtlHazard) begin
            errs++; $display("FAIL load_use_n ctl=%b exp=%b", ctl, CtlHazard);
        end
        tick(1'b1);
        vecs++;
        if (cnt !== 4'd1) begin
            errs++; $display("FAIL load_use_cnt cnt=%0d exp=1", cnt);
        end
        // Bubble now in execute, load in memory.
        e_valid = 1'b0;
        m_valid = 1'b1; m_rd = 5'd5;
        exp_ctl = Fwd ? CtlNone : CtlHazard;
        #1;
        vecs++;
        if (ctl !== exp_ctl) begin
            errs++; $display("FAIL load_use_n1 ctl=%b exp=%b", ctl, exp_ctl);
        end
        tick(!Fwd);
        m_valid = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL load_use_n2 ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
    endtask

    task automatic test_operands();
        idle();
        e_valid = 1'b1; e_op = OP_LOAD; e_rd = 5'd0;
        d_valid = 1'b1; d_op = OP_REG; d_rs1 = 5'd0; d_rs2 = 5'd0;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL x0_dest ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        e_rd = 5'd5;
        d_op = OP_LUI; d_rs1 = 5'd5; d_rs2 = 5'd5;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL lui_unused ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        d_op = OP_JAL; d_rs1 = 5'd5; d_rs2 = 5'd5;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL jal_unused ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        d_op = OP_IMM; d_rs1 = 5'd1; d_rs2 = 5'd5;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL imm_rs2_unused ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        d_op = OP_STORE; d_rs1 = 5'd1; d_rs2 = 5'd5;
        #1;
        vecs++;
        if (ctl !== CtlHazard) begin
            errs++; $display("FAIL store_rs2 ctl=%b exp=%b", ctl, CtlHazard);
        end
        tick(1'b1);
        d_valid = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL d_invalid ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
    endtask

    task automatic test_branch();
        idle();
        e_valid = 1'b1; e_op = OP_LOAD; e_rd = 5'd9;
        d_valid = 1'b1; d_op = OP_REG; d_rs1 = 5'd9; d_rs2 = 5'd9;
        e_jmp = 1'b1;
        #1;
        vecs++;
        if (ctl !== CtlJump) begin
            errs++; $display("FAIL branch_n ctl=%b exp=%b", ctl, CtlJump);
        end
        tick(1'b0);
        e_jmp = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlRedir) begin
            errs++; $display("FAIL branch_n1 ctl=%b exp=%b", ctl, CtlRedir);
        end
        tick(1'b0);
        // Back in RUN, the still-present hazard is acted on again.
        #1;
        vecs++;
        if (ctl !== CtlHazard) begin
            errs++; $display("FAIL branch_n2 ctl=%b exp=%b", ctl, CtlHazard);
        end
        tick(1'b1);
        idle();
        tick(1'b0);
    endtask

    task automatic test_busy_jump();
        do_reset();
        m_busy = 1'b1; e_jmp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (ctl !== CtlBusy) begin
                errs++; $display("FAIL busy_jump_%0d ctl=%b exp=%b", i, ctl, CtlBusy);
            end
            tick(1'b1);
        end
        m_busy = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlJump) begin
            errs++; $display("FAIL busy_jump_flush ctl=%b exp=%b", ctl, CtlJump);
        end
        tick(1'b0);
        e_jmp = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlRedir) begin
            errs++; $display("FAIL busy_jump_redir ctl=%b exp=%b", ctl, CtlRedir);
        end
        tick(1'b0);
        #1;
        vecs++;
        if (ctl !== CtlNone || cnt !== 4'd3) begin
            errs++; $display("FAIL busy_jump_end ctl=%b cnt=%0d exp=%b cnt=3", ctl, cnt, CtlNone);
        end
    endtask

    task automatic test_busy_redirect();
        idle();
        e_jmp = 1'b1;
        #1;
        vecs++;
        if (ctl !== CtlJump) begin
            errs++; $display("FAIL rdbusy_jump ctl=%b exp=%b", ctl, CtlJump);
        end
        tick(1'b0);
        e_jmp = 1'b0; m_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vecs++;
            if (ctl !== CtlRdBusy) begin
                errs++; $display("FAIL rdbusy_hold_%0d ctl=%b exp=%b", i, ctl, CtlRdBusy);
            end
            tick(1'b1);
        end
        m_busy = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlRedir) begin
            errs++; $display("FAIL rdbusy_release ctl=%b exp=%b", ctl, CtlRedir);
        end
        tick(1'b0);
        #1;
        vecs++;
        if (ctl !== CtlNone || cnt !== exp_cnt[3:0]) begin
            errs++; $display("FAIL rdbusy_end ctl=%b cnt=%0d exp=%b cnt=%0d", ctl, cnt, CtlNone,
                             exp_cnt);
        end
    endtask

    task automatic test_no_forward();
        idle();
        exp_ctl = Fwd ? CtlNone : CtlHazard;
        e_valid = 1'b1; e_op = OP_IMM; e_rd = 5'd7;
        d_valid = 1'b1; d_op = OP_REG; d_rs1 = 5'd7; d_rs2 = 5'd7;
        #1;
        vecs++;
        if (ctl !== exp_ctl) begin
            errs++; $display("FAIL nofwd_c1 ctl=%b exp=%b", ctl, exp_ctl);
        end
        tick(!Fwd);
        e_valid = 1'b0;
        m_valid = 1'b1; m_rd = 5'd7;
        #1;
        vecs++;
        if (ctl !== exp_ctl) begin
            errs++; $display("FAIL nofwd_c2 ctl=%b exp=%b", ctl, exp_ctl);
        end
        tick(!Fwd);
        m_valid = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlNone || cnt !== exp_cnt[3:0]) begin
            errs++; $display("FAIL nofwd_c3 ctl=%b cnt=%0d exp=%b cnt=%0d", ctl, cnt, CtlNone,
                             exp_cnt);
        end
        tick(1'b0);
    endtask

    task automatic test_saturation();
        idle();
        m_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b1);
        m_busy = 1'b0;
        #1;
        vecs++;
        if (cnt !== 4'hF) begin
            errs++; $display("FAIL cnt_saturate cnt=%0d exp=15", cnt);
        end
        tick(1'b0);
        vecs++;
        if (cnt !== 4'hF) begin
            errs++; $display("FAIL cnt_hold cnt=%0d exp=15", cnt);
        end
    endtask

    task automatic test_reset_redirect();
        idle();
        e_jmp = 1'b1;
        tick(1'b0);
        e_jmp = 1'b0;
        rst = 1'b1;
        #1;
        vecs++;
        if (ctl !== CtlNone) begin
            errs++; $display("FAIL rst_redir_ctl ctl=%b exp=%b", ctl, CtlNone);
        end
        tick(1'b0);
        rst = 1'b0;
        #1;
        vecs++;
        if (ctl !== CtlNone || cnt !== 4'd0) begin
            errs++; $display("FAIL rst_redir_after ctl=%b cnt=%0d exp=%b cnt=0", ctl, cnt, CtlNone);
        end
        // Confirm RUN: a jump now gives the first-cycle flush pattern.
        e_jmp = 1'b1;
        #1;
        vecs++;
        if (ctl !== CtlJump) begin
            errs++; $display("FAIL rst_redir_run ctl=%b exp=%b", ctl, CtlJump);
        end
        tick(1'b0);
        idle();
        tick(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_operands();
        test_branch();
        test_busy_jump();
        test_busy_redirect();
        test_no_forward();
        test_saturation();
        test_reset_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
